// File: rtl/model_fmt_pkg.sv
// Shared definitions for the quantized model stream format: parser states,
// error codes, field sizes and activation codes.
package model_fmt_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR_LAYERS,
    ST_HDR_BITS,
    ST_L_ROWS,
    ST_L_COLS,
    ST_L_WEIGHTS,
    ST_L_ACT,
    ST_DONE,
    ST_ERROR
  } parse_state_e;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_BAD_LAYERS  = 3'd1;
  localparam logic [2:0] ERR_BAD_BITS    = 3'd2;
  localparam logic [2:0] ERR_BAD_DIM     = 3'd3;
  localparam logic [2:0] ERR_BAD_ACT     = 3'd4;

  localparam logic [2:0] FIELD_BYTES_WORD = 3'd4;
  localparam logic [2:0] FIELD_BYTES_BYTE = 3'd1;

  // The format defines exactly four activation codes.
  localparam logic [7:0] ACT_CODE_0   = 8'd0;
  localparam logic [7:0] ACT_CODE_1   = 8'd1;
  localparam logic [7:0] ACT_CODE_2   = 8'd2;
  localparam logic [7:0] ACT_CODE_3   = 8'd3;
  localparam logic [7:0] MAX_ACT_CODE = ACT_CODE_3;

endpackage

// File: rtl/le_word_assembler.sv
// Collects 1..4 little-endian bytes into a 32-bit word. The word output
// already includes the byte on the bus so a field can be checked on the
// cycle its final byte is accepted.
module le_word_assembler
  import model_fmt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  input  logic [2:0]  num_bytes,
  output logic [31:0] word,
  output logic        last_byte
);

  logic [31:0] data_q, data_d;
  logic [1:0]  cnt_q, cnt_d;

  assign word      = data_q | ({24'd0, byte_in} << {cnt_q, 3'b000});
  assign last_byte = ({1'b0, cnt_q} == (num_bytes - FIELD_BYTES_BYTE));

  // Accumulate bytes; a completed field self-clears for the next one.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clear) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (accept) begin
      if (last_byte) begin
        data_d = '0;
        cnt_d  = '0;
      end else begin
        data_d = word;
        cnt_d  = cnt_q + 2'd1;
      end
    end
  end

  // Byte accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/model_stream_parser.sv
// Parses the quantized model binary format from a valid/ready byte stream,
// emitting tagged weights plus per-layer dimension and activation events.
module model_stream_parser
  import model_fmt_pkg::*;
#(
  parameter int WEIGHT_WIDTH = 8,
  parameter int MAX_LAYERS   = 10,
  parameter int MAX_DIM      = 1024,
  parameter int DIM_WIDTH    = 11,
  parameter int LAYER_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [WEIGHT_WIDTH-1:0] m_weight,
  output logic [LAYER_WIDTH-1:0]  m_layer,
  output logic [DIM_WIDTH-1:0]    m_row,
  output logic [DIM_WIDTH-1:0]    m_col,
  output logic                    m_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    dim_valid,
  output logic [DIM_WIDTH-1:0]    dim_rows,
  output logic [DIM_WIDTH-1:0]    dim_cols,
  output logic                    act_valid,
  output logic [7:0]              act_code,
  output logic [LAYER_WIDTH-1:0]  num_layers,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              error
);

  localparam logic [2:0] WEIGHT_BYTES = 3'(WEIGHT_WIDTH / 8);

  parse_state_e state_q, state_d;
  logic [WEIGHT_WIDTH-1:0] m_weight_q, m_weight_d;
  logic [LAYER_WIDTH-1:0]  m_layer_q, m_layer_d, layer_idx_q, layer_idx_d;
  logic [LAYER_WIDTH-1:0]  num_layers_q, num_layers_d;
  logic [DIM_WIDTH-1:0]    m_row_q, m_row_d, m_col_q, m_col_d;
  logic [DIM_WIDTH-1:0]    row_q, row_d, col_q, col_d;
  logic [DIM_WIDTH-1:0]    rows_q, rows_d, cols_q, cols_d;
  logic                    m_last_q, m_last_d, m_valid_q, m_valid_d;
  logic                    dim_valid_q, dim_valid_d, act_valid_q, act_valid_d;
  logic [7:0]              act_code_q, act_code_d;
  logic                    done_q, done_d;
  logic [2:0]              error_q, error_d;

  logic        accept, asm_clear, asm_last, dim_ok, col_end, row_end;
  logic [2:0]  asm_bytes;
  logic [31:0] asm_word;

  le_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (asm_clear),
    .accept    (accept),
    .byte_in   (s_data),
    .num_bytes (asm_bytes),
    .word      (asm_word),
    .last_byte (asm_last)
  );

  assign accept  = s_valid && s_ready;
  assign dim_ok  = (asm_word >= 32'd1) && (asm_word <= 32'(MAX_DIM));
  assign col_end = (col_q == cols_q - DIM_WIDTH'(1));
  assign row_end = (row_q == rows_q - DIM_WIDTH'(1));

  // Field size and input backpressure per state; the final weight byte
  // only enters when the output slot is free or being freed this cycle.
  always_comb begin
    asm_bytes = FIELD_BYTES_WORD;
    s_ready   = 1'b0;
    case (state_q)
      ST_HDR_LAYERS, ST_L_ROWS, ST_L_COLS: begin
        asm_bytes = FIELD_BYTES_WORD;
        s_ready   = 1'b1;
      end
      ST_HDR_BITS, ST_L_ACT: begin
        asm_bytes = FIELD_BYTES_BYTE;
        s_ready   = 1'b1;
      end
      ST_L_WEIGHTS: begin
        asm_bytes = WEIGHT_BYTES;
        if (m_valid_q && m_last_q) s_ready = 1'b0;
        else if (asm_last)         s_ready = !m_valid_q || m_ready;
        else                       s_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state, field validation and output payload updates.
  always_comb begin
    state_d      = state_q;
    m_weight_d   = m_weight_q;
    m_layer_d    = m_layer_q;
    m_row_d      = m_row_q;
    m_col_d      = m_col_q;
    m_last_d     = m_last_q;
    m_valid_d    = m_valid_q && !m_ready;
    layer_idx_d  = layer_idx_q;
    num_layers_d = num_layers_q;
    row_d        = row_q;
    col_d        = col_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    dim_valid_d  = 1'b0;
    act_valid_d  = 1'b0;
    act_code_d   = act_code_q;
    done_d       = done_q;
    error_d      = error_q;
    asm_clear    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d     = ST_HDR_LAYERS;
          done_d      = 1'b0;
          error_d     = ERR_NONE;
          layer_idx_d = '0;
          row_d       = '0;
          col_d       = '0;
          asm_clear   = 1'b1;
        end
      end
      ST_HDR_LAYERS: begin
        if (accept && asm_last) begin
          if (asm_word >= 32'd1 && asm_word <= 32'(MAX_LAYERS)) begin
            num_layers_d = asm_word[LAYER_WIDTH-1:0];
            state_d      = ST_HDR_BITS;
          end else begin
            error_d = ERR_BAD_LAYERS;
            state_d = ST_ERROR;
          end
        end
      end
      ST_HDR_BITS: begin
        if (accept && asm_last) begin
          if (asm_word >= 32'd1 && asm_word <= 32'(WEIGHT_WIDTH)) begin
            state_d = ST_L_ROWS;
          end else begin
            error_d = ERR_BAD_BITS;
            state_d = ST_ERROR;
          end
        end
      end
      ST_L_ROWS: begin
        if (accept && asm_last) begin
          if (dim_ok) begin
            rows_d  = asm_word[DIM_WIDTH-1:0];
            state_d = ST_L_COLS;
          end else begin
            error_d = ERR_BAD_DIM;
            state_d = ST_ERROR;
          end
        end
      end
      ST_L_COLS: begin
        if (accept && asm_last) begin
          if (dim_ok) begin
            cols_d      = asm_word[DIM_WIDTH-1:0];
            dim_valid_d = 1'b1;
            row_d       = '0;
            col_d       = '0;
            state_d     = ST_L_WEIGHTS;
          end else begin
            error_d = ERR_BAD_DIM;
            state_d = ST_ERROR;
          end
        end
      end
      ST_L_WEIGHTS: begin
        if (accept && asm_last) begin
          m_weight_d = asm_word[WEIGHT_WIDTH-1:0];
          m_layer_d  = layer_idx_q;
          m_row_d    = row_q;
          m_col_d    = col_q;
          m_last_d   = row_end && col_end;
          m_valid_d  = 1'b1;
          if (col_end) begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + DIM_WIDTH'(1);
          end else begin
            col_d = col_q + DIM_WIDTH'(1);
          end
        end
        if (m_valid_q && m_ready && m_last_q) state_d = ST_L_ACT;
      end
      ST_L_ACT: begin
        if (accept && asm_last) begin
          if (asm_word <= 32'(MAX_ACT_CODE)) begin
            act_code_d  = asm_word[7:0];
            act_valid_d = 1'b1;
            if (layer_idx_q == num_layers_q - LAYER_WIDTH'(1)) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              layer_idx_d = layer_idx_q + LAYER_WIDTH'(1);
              state_d     = ST_L_ROWS;
            end
          end else begin
            error_d = ERR_BAD_ACT;
            state_d = ST_ERROR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any pending weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      m_weight_q   <= '0;
      m_layer_q    <= '0;
      m_row_q      <= '0;
      m_col_q      <= '0;
      m_last_q     <= 1'b0;
      m_valid_q    <= 1'b0;
      layer_idx_q  <= '0;
      num_layers_q <= '0;
      row_q        <= '0;
      col_q        <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      dim_valid_q  <= 1'b0;
      act_valid_q  <= 1'b0;
      act_code_q   <= '0;
      done_q       <= 1'b0;
      error_q      <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      m_weight_q   <= m_weight_d;
      m_layer_q    <= m_layer_d;
      m_row_q      <= m_row_d;
      m_col_q      <= m_col_d;
      m_last_q     <= m_last_d;
      m_valid_q    <= m_valid_d;
      layer_idx_q  <= layer_idx_d;
      num_layers_q <= num_layers_d;
      row_q        <= row_d;
      col_q        <= col_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      dim_valid_q  <= dim_valid_d;
      act_valid_q  <= act_valid_d;
      act_code_q   <= act_code_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign m_weight   = m_weight_q;
  assign m_layer    = m_layer_q;
  assign m_row      = m_row_q;
  assign m_col      = m_col_q;
  assign m_last     = m_last_q;
  assign m_valid    = m_valid_q;
  assign dim_valid  = dim_valid_q;
  assign dim_rows   = rows_q;
  assign dim_cols   = cols_q;
  assign act_valid  = act_valid_q;
  assign act_code   = act_code_q;
  assign num_layers = num_layers_q;
  assign done       = done_q;
  assign error      = error_q;
  assign busy       = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);

endmodule

// File: doc/model_stream_parser.md
# model_stream_parser

Synthesizable successor to the simulation-only model file dumper: parses the quantized model binary format from a byte stream rather than `$fread`. The input is valid/ready, as delivered by a DMA or a UART loader. It emits each weight tagged with layer/row/col indices, plus per-layer dimension and activation events, and validates header fields against its parameters. It sits between the model loader and the weight memory writer of the inference engine.

## Interface
- `WEIGHT_WIDTH`, 8: weight width in bits, 8 or 16. Weights occupy `WEIGHT_WIDTH/8` bytes each, little-endian, two's complement.
- `MAX_LAYERS`, 10: largest legal layer count.
- `MAX_DIM`, 1024: largest legal rows or cols value.
- `DIM_WIDTH`, 11: width of the row/col/dimension outputs; must satisfy `MAX_DIM <= 2**DIM_WIDTH - 1`.
- `LAYER_WIDTH`, 4: width of the layer index output.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a parse; honoured only in IDLE/DONE/ERROR.
- `s_data`  in  8: stream byte.
- `s_valid`  in  1: byte valid.
- `s_ready`  out  1: byte accepted when `s_valid && s_ready`.
- `m_weight`  out  WEIGHT_WIDTH: assembled signed weight.
- `m_layer`  out  LAYER_WIDTH: 0-based layer index of `m_weight`.
- `m_row`, `m_col`  out  DIM_WIDTH each: 0-based position of `m_weight`.
- `m_last`  out  1: last weight of the layer.
- `m_valid`  out  1: weight output valid.
- `m_ready`  in  1: downstream accepts.
- `dim_valid`  out  1: one-cycle pulse once rows and cols of a layer are parsed.
- `dim_rows`, `dim_cols`  out  DIM_WIDTH each: current layer dimensions, held.
- `act_valid`  out  1: one-cycle pulse once the activation byte is parsed.
- `act_code`  out  8: activation code, held.
- `num_layers`  out  LAYER_WIDTH: header layer count, held.
- `busy`  out  1: parse in progress.
- `done`  out  1: level signal, set after the last activation byte, cleared by `start`.
- `error`  out  3: 0 = none, 1 = bad layer count, 2 = bad bit width, 3 = bad dimension, 4 = bad activation. Sticky until `start`.

## Operation
- Stream format:
  - 4-byte LE layer count.
  - 1-byte signed-bits value.
  - Then per layer: 4-byte LE rows, 4-byte LE cols, rows×cols weights in row-major order, 1-byte activation.
- States: IDLE → HDR_LAYERS (4 bytes) → HDR_BITS (1) → L_ROWS (4) → L_COLS (4) → L_WEIGHTS → L_ACT (1). From L_ACT, go to L_ROWS if more layers remain, otherwise DONE. Any state may go to ERROR.
- Checks, each made on the accepting cycle of the field's final byte:
  - Layer count must satisfy 1..MAX_LAYERS, else error 1.
  - Bits must satisfy 1..WEIGHT_WIDTH, else error 2.
  - Rows and cols must each satisfy 1..MAX_DIM using the full 32-bit value, else error 3.
  - Activation must be ≤ 3, else error 4.
  - The offending field is consumed and nothing further is emitted.
- `s_ready` rules:
  - 0 in IDLE, DONE and ERROR.
  - 1 in header, dimension and activation states.
  - In L_WEIGHTS: 1 on non-final bytes of a weight; `!m_valid || m_ready` on the final byte.
- Row and col counters advance col-first and wrap col to 0 at `cols-1`. `m_last` is set when row = rows-1 and col = cols-1.
- L_ACT is not entered until the final weight handshake has completed.
- `start` is ignored in any busy state.
- A new `start` in DONE/ERROR clears `done`, `error` and all counters, then enters HDR_LAYERS.

## Timing
- Reset values: all outputs 0, state IDLE. `s_ready` is 0.
- `busy` is 1 from the cycle after `start` until DONE/ERROR is entered.
- Weight latency: `m_valid` rises 1 cycle after the final weight byte is accepted. Payload holds until `m_valid && m_ready`.
- Same-cycle events: the final byte of weight N+1 may be accepted in the same cycle weight N is consumed. Steady state is therefore 1 weight per `WEIGHT_WIDTH/8` cycles.
- `dim_valid` pulses 1 cycle after the final cols byte is accepted.
- `act_valid` pulses 1 cycle after the activation byte is accepted.
- `done` or `error` is visible 1 cycle after the terminating byte is accepted.
- Reset mid-parse: asynchronous return to reset values. A pending `m_valid` is dropped.

## Structure
- Shared package `model_fmt_pkg`:
  - State enum.
  - Error code constants.
  - Field byte counts (4/1).
  - Activation code constants (0..3).
  - `MAX_ACT_CODE`.
- Sub-module `le_word_assembler`:
  - Shifts in up to 4 LE bytes under a byte count.
  - Flags completion.
  - Reused for the 32-bit header/dimension fields and the 1–2 byte weights.

## Test plan
- 1 layer, 2×3, 8-bit: bytes 01 00 00 00, 08, 02 00 00 00, 03 00 00 00, weights FF 01 7F 80 00 05, act 02.
  - 6 weights −1, 1, 127, −128, 0, 5 at (0,0)..(1,2).
  - `m_last` on the 6th weight.
  - `dim_valid` shows 2/3; `act_code` 2; then `done`.
- `WEIGHT_WIDTH`=16, 1×2: weights 34 12, FE FF.
  - Emits 0x1234 and −2.
  - `s_ready` stays high on low bytes.
- 2 layers (2×2 then 1×1) with `m_ready` toggled 1/0 randomly.
  - No weight lost or duplicated.
  - `m_layer` reads 0,0,0,0,1.
  - `s_ready` is low while the output is held.
- Error cases:
  - Layer count 0 gives error 1.
  - cols 00 08 00 00 (2048) with `MAX_DIM`=1024 gives error 3.
  - Activation 07 gives error 4.
  - In every case `m_valid` never rises afterwards and `s_ready` is 0.
- Reset asserted mid-weights:
  - All outputs are 0 immediately.
  - A subsequent `start` with a full valid stream parses correctly.
- `start` pulsed while busy is ignored. `start` in DONE restarts a second full parse.
